// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM states.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder, purely combinational.
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple-carry adder, one nibble per clock,
// LSB nibble first, with the carry chained through a register.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_t        state;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic              carry;
  logic              sign_a;
  logic              sign_b;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        nib_s;
  logic              nib_cout;
  logic [WIDTH+3:0]  sum_cat;
  logic [WIDTH-1:0]  sum_next;
  logic              accept;

  assign accept = (state == IDLE) && start;

  ripple_carry_adder u_rca (
    .a    (opa[3:0]),
    .b    (opb[3:0]),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Written as a wide concat so the shift stays legal when WIDTH == 4.
  assign sum_cat  = {nib_s, sum};
  assign sum_next = sum_cat[WIDTH+3:4];

  // Operand shift registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa    <= a;
      opb    <= b;
      sign_a <= a[WIDTH-1];
      sign_b <= b[WIDTH-1];
    end else if (state == ADD) begin
      opa <= opa >> NIBBLE_W;
      opb <= opb >> NIBBLE_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sum   <= sum_next;
          carry <= nib_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Result flags are taken from the final nibble as it lands.
            cout  <= nib_cout;
            ovf   <= (sign_a == sign_b) && (nib_s[3] != sign_a);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16: directed table,
// multi-cycle corner sequences and randomized operands against an arithmetic model.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests  = 0;
  int failed = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; signed overflow means the true signed
  // result falls outside the W-bit two's-complement range.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                output logic [W-1:0] ms, output logic mco, output logic mov);
    longint u;
    longint si;
    u   = longint'(ma) + longint'(mb) + longint'(mc);
    si  = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
    ms  = u[W-1:0];
    mco = u[W];
    mov = (si > 32767) || (si < -32768);
  endfunction

  // mode 0: plain operation; mode 1: a second start is pulsed during ADD.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [W-1:0] es, input logic eco,
                        input logic eov, input int mode);
    int lat;
    int busy_cnt;
    int dones;
    int overlap;
    logic [W-1:0] s_at;
    logic co_at;
    logic ov_at;
    lat = -1; busy_cnt = 0; dones = 0; overlap = 0;
    s_at = '0; co_at = 1'b0; ov_at = 1'b0;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    for (int n = 1; n <= N + 8; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = n - 1;
          s_at = sum; co_at = cout; ov_at = ovf;
        end
      end
      if (mode == 1 && n == 2) begin
        a = 16'h1111; b = 16'h1111; start = 1'b1;
      end
      if (mode == 1 && n == 3) start = 1'b0;
      if (n == 1) a = ~ta;
    end
    chk({name, " latency"}, lat, N);
    chk({name, " busy_cycles"}, busy_cnt, N);
    chk({name, " done_pulses"}, dones, 1);
    chk({name, " busy_done_overlap"}, overlap, 0);
    chk({name, " sum"}, s_at, es);
    chk({name, " cout"}, co_at, eco);
    chk({name, " ovf"}, ov_at, eov);
    chk({name, " sum_held"}, sum, es);
    chk({name, " cout_held"}, cout, eco);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic rco;
    logic rov;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    int dones;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].s, vecs[i].co, vecs[i].ov, 0);

    run_op("start_in_add", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1);

    // Abort in the second ADD cycle.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    chk("abort ovf", ovf, 0);
    dones = 0;
    for (int n = 0; n < N + 4; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no_done", dones, 0);
    run_op("after_abort", 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rc, rs, rco, rov);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, rco, rov, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
